// File: rtl/mp_ctrl.sv
// Memory-stage sequencer: issues the data access for the MP latch, splits spilled accesses,
// and drives the MP/downstream latch controls. Define MP_CTRL_PERF_CNT_EN for the stall counter.
module mp_ctrl #(
    parameter int AW = 15
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_v,
    input  logic          i_memop,
    input  logic          i_wr,
    input  logic          i_spill,
    input  logic          i_cachable,
    input  logic [AW-1:0] i_req_addr,
    input  logic [1:0]    i_reqSize,
    input  logic          i_flush,
    input  logic          i_wb_stall,
    output logic          o_mem_req,
    output logic [AW-1:0] o_mem_addr,
    output logic [1:0]    o_mem_size,
    output logic          o_mem_wr,
    output logic          o_mem_uc,
    output logic          o_mem_part,
    input  logic          i_mem_ack,
    output logic          o_stall_up,
    output logic          o_wr_down,
    output logic          o_inv_down,
    output logic          o_busy,
    output logic [15:0]   o_stall_cnt
);

    typedef enum logic [2:0] {IDLE, ACC1, ACC2, HOLD, DRAIN} state_t;

    state_t          state;
    state_t          state_n;
    logic            mem;
    logic            req;
    logic            part;
    logic            stall;
    logic            inv;
    logic            busy_q;
    logic            drain_part;
    logic [AW-1:0]   drain_addr;
    logic [AW-1:0]   live_addr;
    logic [AW-3:0]   word_idx;

    assign mem      = i_v & i_memop;
    assign word_idx = i_req_addr[AW-1:2] + {{(AW-3){1'b0}}, 1'b1};
    assign live_addr = part ? {word_idx, 2'b00} : i_req_addr;

    always_comb begin
        state_n = state;
        req     = 1'b0;
        part    = 1'b0;
        stall   = 1'b0;
        case (state)
            IDLE, ACC1: begin
                if (state == ACC1 || (mem && !i_flush)) begin
                    req = 1'b1;
                    if (!i_mem_ack) begin
                        state_n = ACC1;
                        stall   = 1'b1;
                    end else if (i_spill) begin
                        state_n = ACC2;
                        stall   = 1'b1;
                    end else if (i_wb_stall) begin
                        state_n = HOLD;
                        stall   = 1'b1;
                    end else begin
                        state_n = IDLE;
                    end
                end else begin
                    stall = i_wb_stall;
                end
            end
            ACC2: begin
                req  = 1'b1;
                part = 1'b1;
                if (i_mem_ack && !i_wb_stall) begin
                    state_n = IDLE;
                end else begin
                    stall = 1'b1;
                    if (i_mem_ack) state_n = HOLD;
                end
            end
            HOLD: begin
                if (!i_wb_stall) state_n = IDLE;
                else stall = 1'b1;
            end
            DRAIN: begin
                req   = 1'b1;
                part  = drain_part;
                stall = 1'b1;
                if (i_mem_ack) state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase

        // An outstanding request cannot be withdrawn, so a flush without ack must drain it.
        if (i_flush) begin
            stall = 1'b0;
            if ((state == ACC1 || state == ACC2 || state == DRAIN) && !i_mem_ack) state_n = DRAIN;
            else state_n = IDLE;
        end
        inv = i_flush | (stall & !i_wb_stall);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            busy_q     <= 1'b0;
            drain_part <= 1'b0;
            drain_addr <= '0;
        end else begin
            state  <= state_n;
            busy_q <= (state_n != IDLE);
            if (state != DRAIN && state_n == DRAIN) begin
                drain_part <= part;
                drain_addr <= live_addr;
            end
        end
    end

    assign o_mem_req  = req & !rst;
    assign o_mem_addr = (state == DRAIN) ? drain_addr : live_addr;
    assign o_mem_part = part;
    assign o_mem_size = i_reqSize;
    assign o_mem_wr   = i_wr;
    assign o_mem_uc   = !i_cachable;
    assign o_stall_up = stall & !rst;
    assign o_wr_down  = !i_wb_stall & !rst;
    assign o_inv_down = inv & !rst;
    assign o_busy     = busy_q;

`ifdef MP_CTRL_PERF_CNT_EN
    logic [15:0] stall_cnt;

    always_ff @(posedge clk) begin
        if (rst) stall_cnt <= 16'h0000;
        else if (stall && !i_wb_stall && stall_cnt != 16'hFFFF) stall_cnt <= stall_cnt + 16'h0001;
    end

    assign o_stall_cnt = stall_cnt;
`else
    assign o_stall_cnt = 16'h0000;
`endif

endmodule
